lsu_sequencer: RTL
==================

# lsu_sequencer

Multi-cycle load/store sequencer between the EX stage and the data-memory port. Consumes the width (`whb`) and signed/unsigned (`su`) control produced by the control unit. Issues word-aligned, byte-enabled bus transactions over a req/ack handshake and stalls the pipeline until the access completes. Returns sign- or zero-extended load data to writeback and splits word-crossing accesses into two beats.

## Interface
- `ADDR_W`, 32, address width; the data width is fixed at 32.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ex_valid`  in  1  memory op present in EX; held stable while `stall`=1.
- `ex_store`  in  1  1 = store, 0 = load.
- `ex_whb`  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- `ex_su`  in  1  1 = sign-extend load, 0 = zero-extend.
- `ex_addr`  in  ADDR_W  byte address.
- `ex_wdata`  in  32  store data, LSB-justified.
- `stall`  out  1  freeze IF/ID/EX.
- `wb_valid`  out  1  one-cycle completion pulse.
- `wb_rdata`  out  32  extended load result; 0 for stores.
- `misalign_err`  out  1  valid with `wb_valid`.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  write.
- `mem_addr`  out  ADDR_W  word-aligned; bits [1:0] are always 0.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-aligned store data.
- `mem_ack`  in  1  transfer completes in any cycle where `mem_req` and `mem_ack` are both high.
- `mem_rdata`  in  32  valid in the ack cycle.

## Operation
- States are IDLE, BEAT0, BEAT1 and DONE.
- IDLE:
  - On `ex_valid`, capture all `ex_*` inputs.
  - Compute `off`=addr[1:0] and size mask (byte 0001, half 0011, word 1111).
  - Compute `cross` = (word and off≠0) or (half and off=3).
  - Go to BEAT0.
- BEAT0:
  - `mem_req`=1, `mem_addr`={addr[ADDR_W-1:2],2'b00}.
  - `mem_be`=(mask<<off)[3:0], `mem_wdata`=wdata<<(8·off).
  - On ack: latch rdata; go to BEAT1 if `cross`, else DONE.
- BEAT1:
  - `mem_addr` = beat-0 address + 4, wrapping modulo 2^ADDR_W.
  - `mem_be`=(mask<<off)[7:4], `mem_wdata`=wdata>>(8·(4−off)).
  - On ack go to DONE.
- Load assembly: raw = (beat0>>8·off) | (beat1<<8·(4−off)), where the beat-1 term applies only if `cross`.
- Load extension: byte extends raw[7:0], half extends raw[15:0], word passes through; sign-extend when `su`=1, zero-extend otherwise.
- DONE: `wb_valid`=1, `stall`=0; always go to IDLE. IDLE does not accept in the cycle after DONE, giving one bubble so the same instruction is not re-issued.
- `stall` = (IDLE & `ex_valid`) | BEAT0 | BEAT1. This is combinational.
- `mem_req`, `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` hold stable until acked. `mem_req` is 0 in IDLE and DONE.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `wb_valid`, `wb_rdata` and `misalign_err` are all 0. `stall` follows `ex_valid`.
- Aligned access with zero-wait ack: accept at cycle N, ack at N+1, `wb_valid` at N+2.
- Crossing access: accept at N, then BEAT0 and BEAT1 take at least one cycle each, then DONE; `wb_valid` at N+3 at the earliest.
- Each wait cycle (`mem_ack`=0) adds one cycle to the beat.
- `wb_rdata` and `misalign_err` are registered and valid only when `wb_valid`=1; otherwise they hold 0.
- `mem_ack` outside BEAT0/BEAT1 is ignored.
- Reset mid-transaction: `mem_req` drops immediately (asynchronous). The transaction is abandoned with no `wb_valid`.

## Configuration
- Macro: `LSU_MISALIGN_SPLIT_EN`.
- Defined: crossing accesses are split into two beats as above; `misalign_err` is tied to 0.
- Undefined:
  - BEAT1 logic is removed.
  - A crossing access goes IDLE→DONE directly with no bus activity.
  - It completes with `wb_valid`=1, `misalign_err`=1, `wb_rdata`=0.
  - Non-crossing accesses behave identically to the defined build.

## Test plan
- LW, addr 0x100, ack on first cycle, rdata 0xDEADBEEF → `mem_addr`=0x100, `be`=1111, `wb_rdata`=0xDEADBEEF; `wb_valid` 2 cycles after accept.
- LB, `su`=1, addr 0x103, rdata 0x80xxxxxx → `be`=1000, `wb_rdata`=0xFFFFFF80. Same access with LBU → 0x00000080.
- SH, addr 0x202, wdata 0x1234ABCD, 3 wait cycles → `be`=1100, `mem_wdata`=0xABCD0000 held stable for 4 cycles; `stall` high throughout.
- LW, addr 0x1FE, split build → beat 0x1FC `be`=1100 rdata 0xAABBxxxx; beat 0x200 `be`=0011 rdata 0xxxxxCCDD; `wb_rdata`=0xCCDDAABB. Without the macro → no `mem_req`, `misalign_err`=1.
- LH, `su`=0, addr 0xFFFFFFFF → beats at 0xFFFFFFFC and 0x00000000 (wrap).
- `rst_n` low during BEAT0 wait → `mem_req`=0 in the same cycle. After release, state is IDLE and there is no `wb_valid`.

Source files
------------

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer between EX and a req/ack data-memory port.
// Macro LSU_MISALIGN_SPLIT_EN: split word-crossing accesses into two beats; undefined, they complete with misalign_err.
module lsu_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_store,
    input  logic [1:0]        ex_whb,
    input  logic              ex_su,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    output logic              stall,
    output logic              wb_valid,
    output logic [31:0]       wb_rdata,
    output logic              misalign_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] whb);
        case (whb)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] whb,
                                           input logic su);
        case (whb)
            2'b00:   return {{24{su & raw[7]}}, raw[7:0]};
            2'b01:   return {{16{su & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    state_t             state_q;
    logic               bubble_q;
    logic               req_q, we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic               wbv_q, err_q;
    logic [31:0]        rdata_q;

    logic               store_q, su_q;
    logic [1:0]         whb_q, off_q;

    logic [1:0]         off_d;
    logic               cross_d, accept_d;
    logic [31:0]        raw0_d;

    assign off_d    = ex_addr[1:0];
    assign cross_d  = (ex_whb[1] && off_d != 2'b00) || (ex_whb == 2'b01 && off_d == 2'b11);
    assign accept_d = (state_q == IDLE) && ex_valid && !bubble_q;
    assign raw0_d   = mem_rdata >> {off_q, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
    logic               cross_q, reject_d;
    logic [3:0]         be_hi_q;
    logic [31:0]        wd_hi_q, rd0_q, raw1_d;
    logic [7:0]         be_d;
    logic [63:0]        wd_d;

    assign reject_d = 1'b0;
    // Upper halves of the shifted mask/data are the second beat's lanes.
    assign be_d     = {4'b0000, size_mask(ex_whb)} << off_d;
    assign wd_d     = {32'h0, ex_wdata} << {off_d, 3'b000};
    assign raw1_d   = 32'({mem_rdata, rd0_q} >> {off_q, 3'b000});
`else
    logic               reject_d;
    logic [3:0]         be_d;
    logic [31:0]        wd_d;

    assign reject_d = cross_d;
    assign be_d     = size_mask(ex_whb) << off_d;
    assign wd_d     = ex_wdata << {off_d, 3'b000};
`endif

    always_ff @(posedge clk) begin
        if (accept_d) begin
            store_q <= ex_store;
            whb_q   <= ex_whb;
            su_q    <= ex_su;
            off_q   <= off_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            be_hi_q <= be_d[7:4];
            wd_hi_q <= wd_d[63:32];
`endif
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        if (state_q == BEAT0 && mem_ack) begin
            rd0_q <= mem_rdata;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bubble_q <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            wbv_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            cross_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    bubble_q <= 1'b0;
                    if (accept_d) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        cross_q <= cross_d;
`endif
                        if (reject_d) begin
                            state_q <= DONE;
                            wbv_q   <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state_q <= BEAT0;
                            req_q   <= 1'b1;
                            we_q    <= ex_store;
                            addr_q  <= {ex_addr[ADDR_W-1:2], 2'b00};
                            be_q    <= be_d[3:0];
                            wdata_q <= wd_d[31:0];
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        if (cross_q) begin
                            state_q <= BEAT1;
                            addr_q  <= addr_q + ADDR_W'(4);
                            be_q    <= be_hi_q;
                            wdata_q <= wd_hi_q;
                        end else
`endif
                        begin
                            state_q <= DONE;
                            req_q   <= 1'b0;
                            we_q    <= 1'b0;
                            addr_q  <= '0;
                            be_q    <= '0;
                            wdata_q <= '0;
                            wbv_q   <= 1'b1;
                            rdata_q <= store_q ? 32'h0 : extend(raw0_d, whb_q, su_q);
                        end
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                BEAT1: begin
                    if (mem_ack) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        addr_q  <= '0;
                        be_q    <= '0;
                        wdata_q <= '0;
                        wbv_q   <= 1'b1;
                        rdata_q <= store_q ? 32'h0 : extend(raw1_d, whb_q, su_q);
                    end
                end
`endif
                // Bubble keeps the just-retired instruction from being re-accepted.
                DONE: begin
                    state_q  <= IDLE;
                    bubble_q <= 1'b1;
                    wbv_q    <= 1'b0;
                    err_q    <= 1'b0;
                    rdata_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall        = (state_q == IDLE && ex_valid) || state_q == BEAT0 || state_q == BEAT1;
    assign wb_valid     = wbv_q;
    assign wb_rdata     = rdata_q;
    assign misalign_err = err_q;
    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_be       = be_q;
    assign mem_wdata    = wdata_q;

endmodule
